// File: rtl/serial_word_rx.sv
// Serial LSB-first word receiver with output holding register, overrun and framing flags.
// Optional macro SERIAL_NEGATE_EN: two's-complement negation of each word while it shifts in.
module serial_word_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_start,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf,
    output logic             frm_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    count, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_word_d;
    logic             out_valid_d, ovf_d, frm_err_d;
    logic             stored_bit, word_done;
`ifdef SERIAL_NEGATE_EN
    logic             seen_one, seen_one_d;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        count_d     = count;
        shift_d     = shift_q;
        word_done   = 1'b0;
        frm_err_d   = frm_err;
        stored_bit  = in_bit;
`ifdef SERIAL_NEGATE_EN
        seen_one_d  = seen_one;
        // Bits up to and including the first 1 pass through; later bits invert.
        if (seen_one) stored_bit = ~in_bit;
`endif

        if (in_valid) begin
            if (in_start) begin
                if (state == SHIFT) frm_err_d = 1'b1;
                shift_d    = '0;
                shift_d[0] = in_bit;
                count_d    = CW'(1);
                state_d    = SHIFT;
`ifdef SERIAL_NEGATE_EN
                seen_one_d = in_bit;
`endif
            end else if (state == SHIFT) begin
                shift_d[count] = stored_bit;
`ifdef SERIAL_NEGATE_EN
                seen_one_d = seen_one | in_bit;
`endif
                if (count == LAST) begin
                    word_done = 1'b1;
                    state_d   = IDLE;
                    count_d   = '0;
                end else begin
                    count_d = count + 1'b1;
                end
            end
        end

        out_word_d  = out_word;
        out_valid_d = out_valid;
        ovf_d       = ovf;
        if (word_done && (!out_valid || out_ready)) begin
            out_word_d  = shift_d;
            out_valid_d = 1'b1;
        end else if (word_done) begin
            // Holding register still owned by the consumer: drop the new word.
            ovf_d = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            count     <= '0;
            shift_q   <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            frm_err   <= 1'b0;
`ifdef SERIAL_NEGATE_EN
            seen_one  <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            count     <= count_d;
            shift_q   <= shift_d;
            out_word  <= out_word_d;
            out_valid <= out_valid_d;
            ovf       <= ovf_d;
            frm_err   <= frm_err_d;
`ifdef SERIAL_NEGATE_EN
            seen_one  <= seen_one_d;
`endif
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed scenarios plus a randomized run against a word-level model.
module tb_serial_word_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         in_bit = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_start = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_word;
    logic         out_valid, busy, ovf, frm_err;

    int n_checks = 0;
    int n_errors = 0;

    serial_word_rx #(.WIDTH(W)) dut (
        .clk(clk), .res(res), .in_bit(in_bit), .in_valid(in_valid), .in_start(in_start),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // Value the consumer should see for a received word.
    function automatic logic [W-1:0] exp_word(input int v);
`ifdef SERIAL_NEGATE_EN
        return W'(((1 << W) - v) % (1 << W));
`else
        return W'(v);
`endif
    endfunction

    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        in_bit   = b;
        in_valid = 1'b1;
        in_start = s;
    endtask

    task automatic send_word(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) send_bit(v[i], i == 0);
    endtask

    task automatic finish_word();
        @(negedge clk);
        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_reset();
        #2 res = 1'b0;
        #1;
        n_checks++; if (out_word !== '0) begin n_errors++; $display("FAIL reset_word: got %h expected 00", out_word); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL reset_frm: got %b expected 0", frm_err); end
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] v;
        v = 8'h05;
        out_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            send_bit(v[i], i == 0);
            if (i == W - 1) begin
                n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
            end
        end
        finish_word();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_word !== exp_word(5)) begin n_errors++; $display("FAIL basic_word: got %h expected %h", out_word, exp_word(5)); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_one_cycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_negate();
        logic [W-1:0] vals [3];
        vals = '{8'h00, 8'h80, 8'h01};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_word(vals[k]);
            finish_word();
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL negate_valid_%0d: got %b expected 1", k, out_valid); end
            n_checks++; if (out_word !== exp_word(int'(vals[k]))) begin n_errors++; $display("FAIL negate_word_%0d: got %h expected %h", k, out_word, exp_word(int'(vals[k]))); end
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] w2;
        @(negedge clk);
        out_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        finish_word();
        n_checks++; if (out_word !== exp_word(8'h11)) begin n_errors++; $display("FAIL ovf_keep_word: got %h expected %h", out_word, exp_word(8'h11)); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_valid: got %b expected 1", out_valid); end
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        @(negedge clk);
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end

        pulse_reset();
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_cleared: got %b expected 0", ovf); end
        w2 = 8'h44;
        send_word(8'h33);
        for (int i = 0; i < W; i++) begin
            send_bit(w2[i], i == 0);
            if (i == W - 1) out_ready = 1'b1;
        end
        finish_word();
        out_ready = 1'b0;
        n_checks++; if (out_word !== exp_word(8'h44)) begin n_errors++; $display("FAIL xfer_load_word: got %h expected %h", out_word, exp_word(8'h44)); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL xfer_load_valid: got %b expected 1", out_valid); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL xfer_no_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_gaps();
        logic [W-1:0] v;
        int gaps;
        v = 8'hA5;
        out_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                gaps = int'($urandom_range(0, 3));
                repeat (gaps) begin
                    @(negedge clk);
                    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL gaps_busy_gap_%0d: got %b expected 1", i, busy); end
                    in_valid = 1'b0;
                    in_start = 1'($urandom_range(0, 1));
                    in_bit   = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            n_checks++; if (busy !== (i > 0)) begin n_errors++; $display("FAIL gaps_busy_bit_%0d: got %b expected %b", i, busy, (i > 0)); end
            in_bit   = v[i];
            in_valid = 1'b1;
            in_start = (i == 0);
        end
        finish_word();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL gaps_busy_end: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL gaps_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_word !== exp_word(8'hA5)) begin n_errors++; $display("FAIL gaps_word: got %h expected %h", out_word, exp_word(8'hA5)); end
    endtask

    task automatic test_frame_error();
        out_ready = 1'b1;
        n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL frm_initial: got %b expected 0", frm_err); end
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_word(8'h3C);
        finish_word();
        out_ready = 1'b0;
        n_checks++; if (frm_err !== 1'b1) begin n_errors++; $display("FAIL frm_set: got %b expected 1", frm_err); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL frm_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_word !== exp_word(8'h3C)) begin n_errors++; $display("FAIL frm_word: got %h expected %h", out_word, exp_word(8'h3C)); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] v;
        v = 8'h5A;
        for (int i = 0; i < 4; i++) send_bit(v[i], i == 0);
        finish_word();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ares_pre_busy: got %b expected 1", busy); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ares_pre_valid: got %b expected 1", out_valid); end
        #2 res = 1'b0;
        #1;
        n_checks++; if (out_word !== '0) begin n_errors++; $display("FAIL ares_word: got %h expected 00", out_word); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ares_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ares_busy: got %b expected 0", busy); end
        n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL ares_frm: got %b expected 0", frm_err); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL ares_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        res = 1'b1;
        out_ready = 1'b1;
        send_word(8'h81);
        finish_word();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ares_next_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_word !== exp_word(8'h81)) begin n_errors++; $display("FAIL ares_next_word: got %h expected %h", out_word, exp_word(8'h81)); end
    endtask

    // Word-level model: collected bits in a queue, pending output word, sticky flags.
    task automatic test_random();
        bit           mq[$];
        logic [W-1:0] m_word;
        logic         m_valid, m_ovf, m_frm, done, xfer;
        int           val;
        pulse_reset();
        m_word = '0; m_valid = 1'b0; m_ovf = 1'b0; m_frm = 1'b0;
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== m_valid) begin n_errors++; $display("FAIL rand_valid @%0d: got %b expected %b", cyc, out_valid, m_valid); end
            n_checks++; if (out_word !== m_word) begin n_errors++; $display("FAIL rand_word @%0d: got %h expected %h", cyc, out_word, m_word); end
            n_checks++; if (busy !== (mq.size() > 0)) begin n_errors++; $display("FAIL rand_busy @%0d: got %b expected %b", cyc, busy, (mq.size() > 0)); end
            n_checks++; if (ovf !== m_ovf) begin n_errors++; $display("FAIL rand_ovf @%0d: got %b expected %b", cyc, ovf, m_ovf); end
            n_checks++; if (frm_err !== m_frm) begin n_errors++; $display("FAIL rand_frm @%0d: got %b expected %b", cyc, frm_err, m_frm); end

            in_valid  = ($urandom_range(0, 3) != 0);
            in_start  = ($urandom_range(0, 15) == 0);
            in_bit    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));

            xfer = m_valid && out_ready;
            done = 1'b0;
            val  = 0;
            if (in_valid) begin
                if (in_start) begin
                    if (mq.size() > 0) m_frm = 1'b1;
                    mq.delete();
                    mq.push_back(in_bit);
                end else if (mq.size() > 0) begin
                    mq.push_back(in_bit);
                    if (mq.size() == W) begin
                        foreach (mq[k]) val += int'(mq[k]) << k;
                        done = 1'b1;
                        mq.delete();
                    end
                end
            end
            if (done && (!m_valid || out_ready)) begin
                m_word  = exp_word(val);
                m_valid = 1'b1;
            end else if (done) begin
                m_ovf = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
        finish_word();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negate();
        test_overrun();
        test_gaps();
        test_frame_error();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the received word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port res, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port in_bit, input, 1 bit, serial data, LSB first.
REQ-005 The block SHALL have port in_valid, input, 1 bit, in_bit sampled only when high.
REQ-006 The block SHALL have port in_start, input, 1 bit, marks the sampled bit as bit 0 of a word; ignored when in_valid low.
REQ-007 The block SHALL have port out_word, output, WIDTH bits, the assembled word.
REQ-008 The block SHALL have port out_valid, output, 1 bit, out_word holds an untransferred word.
REQ-009 The block SHALL have port out_ready, input, 1 bit, consumer accepts out_word when high with out_valid.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a word is partially received.
REQ-011 The block SHALL have port ovf, output, 1 bit, sticky overrun flag.
REQ-012 The block SHALL have port frm_err, output, 1 bit, sticky framing-error flag.

Function
REQ-013 The block SHALL implement FSM states IDLE and SHIFT plus a separate output holding register, so a new word may be shifted in while the previous word awaits transfer.
REQ-014 In IDLE, bits with in_valid high and in_start low SHALL be discarded; in_valid and in_start high SHALL store bit 0, set bit count to 1, and enter SHIFT.
REQ-015 In SHIFT, each in_valid-high bit SHALL be stored at position count and count incremented; cycles with in_valid low SHALL leave all state unchanged.
REQ-016 When bit WIDTH-1 is sampled, the word SHALL load into out_word, out_valid SHALL be high from the next cycle, and the FSM SHALL return to IDLE (latency: one clk from last-bit edge).
REQ-017 in_valid and in_start high while in SHIFT SHALL abandon the partial word, set frm_err, and restart with the sampled bit as bit 0.
REQ-018 A transfer SHALL occur on any edge where out_valid and out_ready are both high; out_valid SHALL then clear unless a new word loads on the same edge.
REQ-019 A word completing while out_valid is high and out_ready low SHALL be dropped, out_word SHALL keep the older word, and ovf SHALL be set.
REQ-020 A word completing on the same edge as a transfer SHALL load without setting ovf, with out_valid remaining high.
REQ-021 out_word SHALL remain stable while out_valid is high and not transferred.
REQ-022 busy SHALL equal (state == SHIFT).

Reset
REQ-023 res low SHALL immediately force state IDLE, count 0, out_word 0, out_valid 0, busy 0, ovf 0, frm_err 0, regardless of clk.
REQ-024 A word in progress at reset SHALL be discarded; ovf and frm_err SHALL clear only by reset.

Configuration
REQ-025 With macro SERIAL_NEGATE_EN defined, the block SHALL negate each word on the fly: the stored bit equals in_bit until the first 1 bit of the word (inclusive) and the inverse of in_bit afterwards; the seen-one flag clears at every bit 0.
REQ-026 Defined, out_word SHALL equal (2^WIDTH - received value) mod 2^WIDTH; undefined, out_word SHALL equal the raw received bits and no negation logic SHALL exist.

Verification
REQ-027 WIDTH=8, bits 1,0,1,0,0,0,0,0 with start on first, out_ready=1 -> out_word=0x05 (0xFB with SERIAL_NEGATE_EN), out_valid high exactly one cycle after 8th bit edge.
REQ-028 SERIAL_NEGATE_EN, words 0x00 and 0x80 -> out_word 0x00 and 0x80; 0x01 -> 0xFF.
REQ-029 Two back-to-back words, out_ready=0 -> out_word keeps first word, ovf=1; same with out_ready pulsed on second word's completion edge -> second word loaded, ovf=0.
REQ-030 in_start after 3 bits, then full 8-bit word 0x3C -> frm_err=1, out_word=0x3C.
REQ-031 Random in_valid gaps between bits of 0xA5 -> out_word=0xA5, busy high from first to last bit.
REQ-032 res low asynchronously after 4 bits -> all outputs 0 immediately; following word 0x81 received correctly.
